// File: rtl/exe_pkg.sv
// Shared definitions for the execute stage: ALU codes, mul/div opcodes, engine states.
// Latency: n/a (types, constants and small decode helpers only).
// Backpressure: n/a.
package exe_pkg;

    localparam int DATA_W_DEF = 32;

    // ALU operation codes presented on i_alu_ctrl
    localparam logic [3:0] ALU_AND   = 4'h0;
    localparam logic [3:0] ALU_OR    = 4'h1;
    localparam logic [3:0] ALU_ADD   = 4'h2;
    localparam logic [3:0] ALU_ADDU  = 4'h3;
    localparam logic [3:0] ALU_XOR   = 4'h4;
    localparam logic [3:0] ALU_NOR   = 4'h5;
    localparam logic [3:0] ALU_SUB   = 4'h6;
    localparam logic [3:0] ALU_SUBU  = 4'h7;
    localparam logic [3:0] ALU_SLT   = 4'h8;
    localparam logic [3:0] ALU_SLTU  = 4'h9;
    localparam logic [3:0] ALU_SLL   = 4'hA;
    localparam logic [3:0] ALU_SRL   = 4'hB;
    localparam logic [3:0] ALU_SRA   = 4'hC;
    localparam logic [3:0] ALU_PASSB = 4'hD;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MFHI  = 3'd5,
        MD_MFLO  = 3'd6,
        MD_RSVD  = 3'd7
    } md_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } md_state_t;

    // Opcodes that start the multiply/divide engine
    function automatic logic md_is_arith(input md_op_t op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    // Opcodes that touch the engine or HI/LO and must wait while it is working
    function automatic logic md_uses_unit(input md_op_t op);
        return md_is_arith(op) || (op == MD_MFHI) || (op == MD_MFLO);
    endfunction

endpackage

// File: rtl/e_muldiv_iter.sv
// Iterative multiply/divide engine with HI/LO (shift-add multiply, restoring divide).
// Latency: HI/LO written MD_CYCLES+1 edges after i_start; EXE_MULT_FAST_EN makes MULT/MULTU write on the start edge.
// Backpressure: i_start is only honoured in IDLE; o_idle low tells the parent to stall engine users.
module e_muldiv_iter
    import exe_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MD_CYCLES = DATA_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  md_op_t            i_op,
    input  logic [DATA_W-1:0] i_rs,
    input  logic [DATA_W-1:0] i_rt,
    output logic [DATA_W-1:0] o_hi,
    output logic [DATA_W-1:0] o_lo,
    output logic              o_idle
);

    localparam int CNT_W = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_CYCLES - 1);

    md_state_t             r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [2*DATA_W-1:0]   r_acc;      // {partial/remainder, multiplier/quotient}
    logic [DATA_W-1:0]     r_dvsr;     // multiplicand or divisor magnitude
    logic                  r_is_div;
    logic                  r_neg_a;    // negate product or quotient at the end
    logic                  r_neg_r;    // negate remainder at the end
    logic                  r_divz;
    logic [DATA_W-1:0]     r_rs_raw;   // original dividend, returned in HI on divide by zero
    logic [DATA_W-1:0]     r_hi;
    logic [DATA_W-1:0]     r_lo;

    logic                  w_signed_op;
    logic                  w_is_div;
    logic [DATA_W-1:0]     w_abs_rs;
    logic [DATA_W-1:0]     w_abs_rt;
    logic [DATA_W:0]       w_mul_sum;
    logic [2*DATA_W-1:0]   w_mul_next;
    logic [2*DATA_W:0]     w_div_shl;
    logic [DATA_W:0]       w_div_rem;
    logic [DATA_W:0]       w_div_diff;
    logic [2*DATA_W-1:0]   w_div_next;
    logic [2*DATA_W-1:0]   w_prod;
    logic [DATA_W-1:0]     w_quot;
    logic [DATA_W-1:0]     w_rem;

    // Operand magnitudes for the signed variants; the engine itself is unsigned
    always_comb begin
        w_signed_op = (i_op == MD_MULT) || (i_op == MD_DIV);
        w_is_div    = (i_op == MD_DIV) || (i_op == MD_DIVU);
        w_abs_rs    = (w_signed_op && i_rs[DATA_W-1]) ? (~i_rs + 1'b1) : i_rs;
        w_abs_rt    = (w_signed_op && i_rt[DATA_W-1]) ? (~i_rt + 1'b1) : i_rt;
    end

    // One iteration step: multiply adds the multiplicand when the low bit is set then shifts right;
    // divide shifts left and keeps the trial subtraction only when it does not go negative
    always_comb begin
        w_mul_sum  = {1'b0, r_acc[2*DATA_W-1:DATA_W]}
                   + (r_acc[0] ? {1'b0, r_dvsr} : {(DATA_W+1){1'b0}});
        w_mul_next = {w_mul_sum, r_acc[DATA_W-1:1]};
        w_div_shl  = {r_acc, 1'b0};
        w_div_rem  = w_div_shl[2*DATA_W:DATA_W];
        w_div_diff = w_div_rem - {1'b0, r_dvsr};
        if (!w_div_diff[DATA_W]) begin
            w_div_next = {w_div_diff[DATA_W-1:0], w_div_shl[DATA_W-1:1], 1'b1};
        end else begin
            w_div_next = {w_div_rem[DATA_W-1:0], w_div_shl[DATA_W-1:0]};
        end
    end

    // Sign correction applied when the iterations are finished
    always_comb begin
        w_prod = r_neg_a ? (~r_acc + 1'b1) : r_acc;
        w_quot = r_neg_a ? (~r_acc[DATA_W-1:0] + 1'b1) : r_acc[DATA_W-1:0];
        w_rem  = r_neg_r ? (~r_acc[2*DATA_W-1:DATA_W] + 1'b1) : r_acc[2*DATA_W-1:DATA_W];
    end

`ifdef EXE_MULT_FAST_EN
    logic [2*DATA_W-1:0] w_ext_rs;
    logic [2*DATA_W-1:0] w_ext_rt;
    logic [2*DATA_W-1:0] w_fast_prod;
    logic                w_fast_mul;

    // Native multiply: low 2W bits of the product of the extended operands are exact for both signednesses
    always_comb begin
        w_ext_rs    = w_signed_op ? {{DATA_W{i_rs[DATA_W-1]}}, i_rs} : {{DATA_W{1'b0}}, i_rs};
        w_ext_rt    = w_signed_op ? {{DATA_W{i_rt[DATA_W-1]}}, i_rt} : {{DATA_W{1'b0}}, i_rt};
        w_fast_prod = w_ext_rs * w_ext_rt;
        w_fast_mul  = (i_op == MD_MULT) || (i_op == MD_MULTU);
    end
`endif

    // Engine FSM: IDLE latches operands, BUSY iterates MD_CYCLES times, DONE commits HI/LO
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_dvsr   <= '0;
            r_is_div <= 1'b0;
            r_neg_a  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_divz   <= 1'b0;
            r_rs_raw <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
`ifdef EXE_MULT_FAST_EN
                        if (w_fast_mul) begin
                            r_hi <= w_fast_prod[2*DATA_W-1:DATA_W];
                            r_lo <= w_fast_prod[DATA_W-1:0];
                        end else
`endif
                        begin
                            r_state  <= ST_BUSY;
                            r_cnt    <= '0;
                            r_acc    <= {{DATA_W{1'b0}}, w_abs_rs};
                            r_dvsr   <= w_abs_rt;
                            r_is_div <= w_is_div;
                            r_neg_a  <= w_signed_op && (i_rs[DATA_W-1] ^ i_rt[DATA_W-1]);
                            r_neg_r  <= w_signed_op && w_is_div && i_rs[DATA_W-1];
                            r_divz   <= (i_rt == '0);
                            r_rs_raw <= i_rs;
                        end
                    end
                end
                ST_BUSY: begin
                    r_acc <= r_is_div ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (r_is_div) begin
                        if (r_divz) begin
                            r_lo <= '1;
                            r_hi <= r_rs_raw;
                        end else begin
                            r_lo <= w_quot;
                            r_hi <= w_rem;
                        end
                    end else begin
                        r_hi <= w_prod[2*DATA_W-1:DATA_W];
                        r_lo <= w_prod[DATA_W-1:0];
                    end
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_hi   = r_hi;
    assign o_lo   = r_lo;
    assign o_idle = (r_state == ST_IDLE);

endmodule

// File: rtl/e_execute_unit.sv
// MIPS execute stage: operand-B select, ALU, EX/MEM result register, HI/LO engine host (EXE_MULT_FAST_EN = native MULT).
// Latency: 1 cycle from an unstalled valid instruction to o_valid; mul/div HI/LO ready MD_CYCLES+1 edges after accept.
// Backpressure: o_stall is combinational; engine users stall while it is not idle, plain ALU ops always proceed.
module e_execute_unit
    import exe_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MD_CYCLES = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    input  logic [3:0]        i_alu_ctrl,
    input  logic              i_alu_src,
    input  logic [DATA_W-1:0] i_data_rs,
    input  logic [DATA_W-1:0] i_data_rt,
    input  logic [DATA_W-1:0] i_data_immD,
    input  logic [4:0]        i_shamt,
    input  logic [2:0]        i_md_op,
    output logic [DATA_W-1:0] o_data_aluE,
    output logic              o_valid,
    output logic              o_zero,
    output logic              o_overflow,
    output logic              o_stall
);

    localparam int MSB = DATA_W - 1;

    md_op_t            w_md_op;
    logic [DATA_W-1:0] w_op_b;
    logic [DATA_W-1:0] w_sum;
    logic [DATA_W-1:0] w_diff;
    logic [DATA_W-1:0] w_alu_res;
    logic              w_alu_ovf;
    logic [DATA_W-1:0] w_res;
    logic              w_ovf;
    logic              w_load;
    logic              w_md_start;
    logic              w_md_idle;
    logic [DATA_W-1:0] w_hi;
    logic [DATA_W-1:0] w_lo;

    logic [DATA_W-1:0] r_res;
    logic              r_valid;
    logic              r_zero;
    logic              r_ovf;

    assign w_md_op    = md_op_t'(i_md_op);
    assign w_op_b     = i_alu_src ? i_data_immD : i_data_rt;
    assign w_sum      = i_data_rs + w_op_b;
    assign w_diff     = i_data_rs - w_op_b;
    assign o_stall    = !w_md_idle && i_valid && md_uses_unit(w_md_op);
    assign w_load     = i_valid && !o_stall;
    assign w_md_start = w_load && md_is_arith(w_md_op);

    // Combinational ALU; overflow is only meaningful for the signed add/subtract
    always_comb begin
        w_alu_res = '0;
        w_alu_ovf = 1'b0;
        case (i_alu_ctrl)
            ALU_AND:   w_alu_res = i_data_rs & w_op_b;
            ALU_OR:    w_alu_res = i_data_rs | w_op_b;
            ALU_XOR:   w_alu_res = i_data_rs ^ w_op_b;
            ALU_NOR:   w_alu_res = ~(i_data_rs | w_op_b);
            ALU_ADD: begin
                w_alu_res = w_sum;
                w_alu_ovf = (i_data_rs[MSB] == w_op_b[MSB]) && (w_sum[MSB] != i_data_rs[MSB]);
            end
            ALU_ADDU:  w_alu_res = w_sum;
            ALU_SUB: begin
                w_alu_res = w_diff;
                w_alu_ovf = (i_data_rs[MSB] != w_op_b[MSB]) && (w_diff[MSB] != i_data_rs[MSB]);
            end
            ALU_SUBU:  w_alu_res = w_diff;
            ALU_SLT:   w_alu_res = {{(DATA_W-1){1'b0}}, ($signed(i_data_rs) < $signed(w_op_b))};
            ALU_SLTU:  w_alu_res = {{(DATA_W-1){1'b0}}, (i_data_rs < w_op_b)};
            ALU_SLL:   w_alu_res = w_op_b << i_shamt;
            ALU_SRL:   w_alu_res = w_op_b >> i_shamt;
            ALU_SRA:   w_alu_res = $signed(w_op_b) >>> i_shamt;
            ALU_PASSB: w_alu_res = w_op_b;
            default:   w_alu_res = '0;
        endcase
    end

    // Engine-related opcodes replace the ALU result: starts report 0, moves report HI/LO
    always_comb begin
        w_res = w_alu_res;
        w_ovf = w_alu_ovf;
        case (w_md_op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                w_res = '0;
                w_ovf = 1'b0;
            end
            MD_MFHI: begin
                w_res = w_hi;
                w_ovf = 1'b0;
            end
            MD_MFLO: begin
                w_res = w_lo;
                w_ovf = 1'b0;
            end
            default: begin
                w_res = w_alu_res;
                w_ovf = w_alu_ovf;
            end
        endcase
    end

    // EX/MEM register: load on an accepted instruction, otherwise drop valid and hold the rest
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_res   <= '0;
            r_valid <= 1'b0;
            r_zero  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_valid <= w_load;
            if (w_load) begin
                r_res  <= w_res;
                r_zero <= (w_res == '0);
                r_ovf  <= w_ovf;
            end
        end
    end

    e_muldiv_iter #(
        .DATA_W    (DATA_W),
        .MD_CYCLES (MD_CYCLES)
    ) u_muldiv (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_start (w_md_start),
        .i_op    (w_md_op),
        .i_rs    (i_data_rs),
        .i_rt    (i_data_rt),
        .o_hi    (w_hi),
        .o_lo    (w_lo),
        .o_idle  (w_md_idle)
    );

    assign o_data_aluE = r_res;
    assign o_valid     = r_valid;
    assign o_zero      = r_zero;
    assign o_overflow  = r_ovf;

endmodule

// File: tb/tb_e_execute_unit.sv
// Self-checking bench for e_execute_unit: directed cases plus randomized traffic against a reference model.
// Latency: model expects results one edge after an unstalled issue, HI/LO MD_CYCLES+1 edges after a start.
// Backpressure: model predicts o_stall from a countdown of cycles until the engine is free.
module tb_e_execute_unit;

    localparam int DATA_W    = 32;
    localparam int MD_CYCLES = 32;
`ifdef EXE_MULT_FAST_EN
    localparam bit MUL_FAST = 1'b1;
`else
    localparam bit MUL_FAST = 1'b0;
`endif
    localparam int MUL_STALLS = MUL_FAST ? 0 : MD_CYCLES + 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_valid;
    logic [3:0]        i_alu_ctrl;
    logic              i_alu_src;
    logic [DATA_W-1:0] i_data_rs;
    logic [DATA_W-1:0] i_data_rt;
    logic [DATA_W-1:0] i_data_immD;
    logic [4:0]        i_shamt;
    logic [2:0]        i_md_op;
    logic [DATA_W-1:0] o_data_aluE;
    logic              o_valid;
    logic              o_zero;
    logic              o_overflow;
    logic              o_stall;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [31:0] m_hi, m_lo, m_pend_hi, m_pend_lo, m_res;
    logic        m_valid, m_zero, m_ovf;
    int          m_remain;   // edges until the engine is free and pending HI/LO land

    always #5 clk = ~clk;

    e_execute_unit #(.DATA_W(DATA_W), .MD_CYCLES(MD_CYCLES)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_valid     (i_valid),
        .i_alu_ctrl  (i_alu_ctrl),
        .i_alu_src   (i_alu_src),
        .i_data_rs   (i_data_rs),
        .i_data_rt   (i_data_rt),
        .i_data_immD (i_data_immD),
        .i_shamt     (i_shamt),
        .i_md_op     (i_md_op),
        .o_data_aluE (o_data_aluE),
        .o_valid     (o_valid),
        .o_zero      (o_zero),
        .o_overflow  (o_overflow),
        .o_stall     (o_stall)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ALU reference from plain integer arithmetic
    function automatic void ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                    input logic [4:0] sh, output logic [31:0] r, output logic ov);
        longint sa, sb, s;
        logic signed [31:0] sbv;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sbv = b;
        r = 32'h0;
        ov = 1'b0;
        case (c)
            4'h0: r = a & b;
            4'h1: r = a | b;
            4'h4: r = a ^ b;
            4'h5: r = ~(a | b);
            4'h2: begin s = sa + sb; r = s[31:0]; ov = (s != longint'($signed(s[31:0]))); end
            4'h3: r = a + b;
            4'h6: begin s = sa - sb; r = s[31:0]; ov = (s != longint'($signed(s[31:0]))); end
            4'h7: r = a - b;
            4'h8: r = (sa < sb) ? 32'd1 : 32'd0;
            4'h9: r = (a < b) ? 32'd1 : 32'd0;
            4'hA: r = b << sh;
            4'hB: r = b >> sh;
            4'hC: r = sbv >>> sh;
            4'hD: r = b;
            default: r = 32'h0;
        endcase
    endfunction

    // Multiply/divide reference using native 64-bit arithmetic
    function automatic void ref_md(input logic [2:0] md, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] hi, output logic [31:0] lo);
        longint sa, sb, p;
        logic [63:0] u;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        hi = 32'h0;
        lo = 32'h0;
        case (md)
            3'd1: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
            3'd2: begin u = {32'h0, a} * {32'h0, b}; hi = u[63:32]; lo = u[31:0]; end
            3'd3, 3'd4: begin
                if (b == 32'h0) begin
                    lo = 32'hFFFF_FFFF;
                    hi = a;
                end else if (md == 3'd3) begin
                    p = sa / sb; lo = p[31:0];
                    p = sa % sb; hi = p[31:0];
                end else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
            default: ;
        endcase
    endfunction

    task automatic model_reset();
        m_hi = 0; m_lo = 0; m_pend_hi = 0; m_pend_lo = 0;
        m_res = 0; m_valid = 0; m_zero = 0; m_ovf = 0;
        m_remain = 0;
    endtask

    // One cycle: apply inputs, check stall, clock, update model, check registered outputs
    task automatic drive(input logic v, input logic [3:0] ctrl, input logic src,
                         input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] imm,
                         input logic [4:0] sh, input logic [2:0] md, output logic stalled);
        logic exp_stall, load, ov, is_md;
        logic [31:0] r, b, nh, nl;
        i_valid = v; i_alu_ctrl = ctrl; i_alu_src = src; i_data_rs = rs;
        i_data_rt = rt; i_data_immD = imm; i_shamt = sh; i_md_op = md;
        #1;
        stalled   = o_stall;
        is_md     = (md >= 3'd1) && (md <= 3'd6);
        exp_stall = (m_remain > 0) && v && is_md;
        check("stall", {31'h0, o_stall}, {31'h0, exp_stall});
        load = v && !exp_stall;
        b = src ? imm : rt;
        ref_alu(ctrl, rs, b, sh, r, ov);
        if (md >= 3'd1 && md <= 3'd4) begin r = 0; ov = 0; end
        else if (md == 3'd5) begin r = m_hi; ov = 0; end
        else if (md == 3'd6) begin r = m_lo; ov = 0; end
        @(posedge clk);
        #1;
        if (m_remain > 0) begin
            m_remain--;
            if (m_remain == 0) begin m_hi = m_pend_hi; m_lo = m_pend_lo; end
        end
        if (load && md >= 3'd1 && md <= 3'd4) begin
            ref_md(md, rs, rt, nh, nl);
            if (MUL_FAST && md <= 3'd2) begin
                m_hi = nh; m_lo = nl;
            end else begin
                m_pend_hi = nh; m_pend_lo = nl; m_remain = MD_CYCLES + 1;
            end
        end
        m_valid = load;
        if (load) begin m_res = r; m_zero = (r == 0); m_ovf = ov; end
        check("valid", {31'h0, o_valid}, {31'h0, m_valid});
        check("result", o_data_aluE, m_res);
        check("zero", {31'h0, o_zero}, {31'h0, m_zero});
        check("ovf", {31'h0, o_overflow}, {31'h0, m_ovf});
    endtask

    task automatic alu(input logic [3:0] ctrl, input logic src, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [31:0] imm, input logic [4:0] sh);
        logic st;
        drive(1'b1, ctrl, src, rs, rt, imm, sh, 3'd0, st);
    endtask

    task automatic md_issue(input logic [2:0] md, input logic [31:0] rs, input logic [31:0] rt,
                            output logic st);
        drive(1'b1, 4'h0, 1'b0, rs, rt, 32'h0, 5'd0, md, st);
    endtask

    // Re-present an engine opcode until accepted; bounded, returns the stall count
    task automatic md_retry(input logic [2:0] md, input logic [31:0] rs, input logic [31:0] rt,
                            output int n);
        logic st;
        n = 0;
        for (int k = 0; k < 100; k++) begin
            md_issue(md, rs, rt, st);
            if (!st) break;
            n++;
        end
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        logic st;
        int   n;
        logic [2:0] md;

        rst_n = 1'b0;
        i_valid = 0; i_alu_ctrl = 0; i_alu_src = 0; i_data_rs = 0;
        i_data_rt = 0; i_data_immD = 0; i_shamt = 0; i_md_op = 0;
        model_reset();
        #3;
        check("rst_result", o_data_aluE, 32'h0);
        check("rst_valid", {31'h0, o_valid}, 32'h0);
        check("rst_stall", {31'h0, o_stall}, 32'h0);
        #19 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Signed add overflow on the immediate path, then the unsigned form
        alu(4'h2, 1'b1, 32'h7FFF_FFFF, 32'h0, 32'h1, 5'd0);
        check("add_res", o_data_aluE, 32'h8000_0000);
        check("add_ovf", {31'h0, o_overflow}, 32'h1);
        check("add_zero", {31'h0, o_zero}, 32'h0);
        alu(4'h3, 1'b1, 32'h7FFF_FFFF, 32'h0, 32'h1, 5'd0);
        check("addu_ovf", {31'h0, o_overflow}, 32'h0);

        alu(4'h8, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h0, 5'd0);
        check("slt", o_data_aluE, 32'h1);
        alu(4'h9, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h0, 5'd0);
        check("sltu", o_data_aluE, 32'h0);
        check("sltu_zero", {31'h0, o_zero}, 32'h1);

        // MULT -3 * 7
        md_issue(3'd1, 32'hFFFF_FFFD, 32'd7, st);
        check("mult_issue_stall", {31'h0, st}, 32'h0);
        md_retry(3'd6, 32'h0, 32'h0, n);
        check("mflo_stall_cycles", n, MUL_STALLS);
        check("mult_lo", o_data_aluE, 32'hFFFF_FFEB);
        md_retry(3'd5, 32'h0, 32'h0, n);
        check("mult_hi", o_data_aluE, 32'hFFFF_FFFF);

        // DIV -7 / 2 and DIVU 5 / 0
        md_issue(3'd3, 32'hFFFF_FFF9, 32'd2, st);
        md_retry(3'd6, 32'h0, 32'h0, n);
        check("div_lo", o_data_aluE, 32'hFFFF_FFFD);
        md_retry(3'd5, 32'h0, 32'h0, n);
        check("div_hi", o_data_aluE, 32'hFFFF_FFFF);
        md_issue(3'd4, 32'd5, 32'h0, st);
        md_retry(3'd6, 32'h0, 32'h0, n);
        check("divz_lo", o_data_aluE, 32'hFFFF_FFFF);
        md_retry(3'd5, 32'h0, 32'h0, n);
        check("divz_hi", o_data_aluE, 32'h5);

        // ALU op during BUSY proceeds; a second MULT waits for the engine
        md_issue(3'd2, 32'h0001_0000, 32'h0001_0000, st);
        drive(1'b1, 4'h1, 1'b0, 32'h00F0, 32'h000F, 32'h0, 5'd0, 3'd0, st);
        check("alu_busy_stall", {31'h0, st}, 32'h0);
        check("alu_busy_res", o_data_aluE, 32'h00FF);
        md_retry(3'd1, 32'd6, 32'hFFFF_FFFE, n);
        check("mult2_waited", n, MUL_FAST ? 0 : MD_CYCLES);
        md_retry(3'd6, 32'h0, 32'h0, n);
        check("mult2_lo", o_data_aluE, 32'hFFFF_FFF4);

        // Reset while the engine is at iteration 10
        md_issue(3'd2, 32'h1234_5678, 32'h9ABC_DEF0, st);
        for (int k = 0; k < 9; k++) drive(1'b0, 4'h0, 1'b0, 0, 0, 0, 5'd0, 3'd0, st);
        alu(4'h3, 1'b1, 32'd5, 32'h0, 32'd9, 5'd0);
        #1;
        rst_n = 1'b0;
        i_valid = 1'b1; i_md_op = 3'd1;
        #1;
        check("midrst_result", o_data_aluE, 32'h0);
        check("midrst_valid", {31'h0, o_valid}, 32'h0);
        check("midrst_stall", {31'h0, o_stall}, 32'h0);
        model_reset();
        i_valid = 1'b0;
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        md_retry(3'd5, 32'h0, 32'h0, n);
        check("rst_mfhi", o_data_aluE, 32'h0);
        md_retry(3'd6, 32'h0, 32'h0, n);
        check("rst_mflo", o_data_aluE, 32'h0);

        // Randomized traffic
        for (int it = 0; it < 2000; it++) begin
            md = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 6)) : 3'($urandom_range(0, 1) * 7);
            drive(($urandom_range(0, 4) != 0), 4'($urandom()), 1'($urandom()), rnd_opnd(), rnd_opnd(),
                  rnd_opnd(), 5'($urandom()), md, st);
        end
        md_retry(3'd5, 32'h0, 32'h0, n);
        md_retry(3'd6, 32'h0, 32'h0, n);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
